e_mdu: RTL and testbench

- Execute-stage multiply/divide unit. Sits beside the E-stage ALU and takes the same forwarded rs/rt operands.
- Holds the architectural HI/LO registers and runs multi-cycle mult/multu/div/divu. Executes mthi/mtlo in one cycle.
- Drives busy to the hazard unit. While an operation is in flight, the hazard unit stalls D-stage MDU instructions and mfhi/mflo.

---
 rtl/e_mdu_if.sv | 13 +
 rtl/e_mdu.sv | 113 +++++++++++
 tb/tb_e_mdu.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/e_mdu_if.sv
// Operand, command and result bundle between the E stage and the multiply/divide unit.
interface e_mdu_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  MDUOp;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output A, B, MDUOp, start, input busy, HI, LO);
  modport slave  (input A, B, MDUOp, start, output busy, HI, LO);
endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: HI/LO registers, fixed-latency mult/div, single-cycle mthi/mtlo.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu accumulation into HI/LO.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic    clk,
  input logic    reset,
  e_mdu_if.slave mdu
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } mdu_op_e;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  logic [3:0]  cnt;
  logic [31:0] hi, lo, phi, plo;

  logic [63:0] prod_s, prod_u;
  logic [31:0] dvsr, mag_a, mag_b, sq, sr, q_s, r_s, uq, ur;
  logic        b_nz;

  logic        acc_go;
  logic [3:0]  acc_n;
  logic [63:0] acc_res;

  always_comb begin
    prod_s = $signed({{32{mdu.A[31]}}, mdu.A}) * $signed({{32{mdu.B[31]}}, mdu.B});
    prod_u = {32'd0, mdu.A} * {32'd0, mdu.B};
    b_nz   = (mdu.B != '0);
    // Divisor forced to 1 on zero so the dividers never see x; result is discarded then.
    dvsr   = b_nz ? mdu.B : 32'd1;
    uq     = mdu.A / dvsr;
    ur     = mdu.A % dvsr;
    mag_a  = mdu.A[31] ? -mdu.A : mdu.A;
    mag_b  = (b_nz && mdu.B[31]) ? -mdu.B : dvsr;
    sq     = mag_a / mag_b;
    sr     = mag_a % mag_b;
    q_s    = (mdu.A[31] ^ mdu.B[31]) ? -sq : sq;
    r_s    = mdu.A[31] ? -sr : sr;
  end

  always_comb begin
    acc_go  = 1'b0;
    acc_n   = '0;
    acc_res = {hi, lo};
    case (mdu.MDUOp)
      OP_MULT:  begin acc_go = 1'b1; acc_n = MULT_N; acc_res = prod_s; end
      OP_MULTU: begin acc_go = 1'b1; acc_n = MULT_N; acc_res = prod_u; end
      OP_DIV: begin
        acc_go = 1'b1;
        acc_n  = DIV_N;
        if (b_nz) acc_res = {r_s, q_s};
      end
      OP_DIVU: begin
        acc_go = 1'b1;
        acc_n  = DIV_N;
        if (b_nz) acc_res = {ur, uq};
      end
`ifdef MDU_MADD_EN
      OP_MADD:  begin acc_go = 1'b1; acc_n = MULT_N; acc_res = {hi, lo} + prod_s; end
      OP_MADDU: begin acc_go = 1'b1; acc_n = MULT_N; acc_res = {hi, lo} + prod_u; end
      OP_MSUB:  begin acc_go = 1'b1; acc_n = MULT_N; acc_res = {hi, lo} - prod_s; end
      OP_MSUBU: begin acc_go = 1'b1; acc_n = MULT_N; acc_res = {hi, lo} - prod_u; end
`endif
      default: ;
    endcase
  end

  // Result is fully computed at accept; the counter only models latency.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
      hi  <= '0;
      lo  <= '0;
      phi <= '0;
      plo <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        hi <= phi;
        lo <= plo;
      end
    end else if (mdu.start) begin
      if (acc_go) begin
        cnt        <= acc_n;
        {phi, plo} <= acc_res;
      end else if (mdu.MDUOp == OP_MTHI) begin
        hi <= mdu.A;
      end else if (mdu.MDUOp == OP_MTLO) begin
        lo <= mdu.A;
      end
    end
  end

  assign mdu.busy = (cnt != '0);
  assign mdu.HI   = hi;
  assign mdu.LO   = lo;

endmodule

// File: tb/tb_e_mdu.sv
// Randomized self-checking bench for e_mdu against an arithmetic reference model.
module tb_e_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [31:0] mhi, mlo;

  e_mdu_if bus ();

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void ref_op(input int op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] cur, output logic [63:0] nxt, output int n);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    nxt = cur;
    n   = 0;
    case (op)
      1: begin n = MC; nxt = sa * sb; end
      2: begin n = MC; nxt = ua * ub; end
      3: begin
        n = DC;
        if (b != 0) begin
          q   = sa / sb;
          r   = sa % sb;
          nxt = {r[31:0], q[31:0]};
        end
      end
      4: begin
        n = DC;
        if (b != 0) nxt = {32'(ua % ub), 32'(ua / ub)};
      end
      5: nxt[63:32] = a;
      6: nxt[31:0]  = a;
`ifdef MDU_MADD_EN
      7:  begin n = MC; nxt = cur + sa * sb; end
      8:  begin n = MC; nxt = cur + ua * ub; end
      9:  begin n = MC; nxt = cur - sa * sb; end
      10: begin n = MC; nxt = cur - ua * ub; end
`endif
      default: ;
    endcase
  endfunction

  // Entered and left just after a falling edge.
  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b, input int inj);
    logic [63:0] cur, nxt;
    int n;
    cur = {mhi, mlo};
    ref_op(op, a, b, cur, nxt, n);
    bus.start = 1'b1;
    bus.MDUOp = 4'(op);
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.MDUOp = 4'd0;
    for (int i = 0; i < n; i++) begin
      chk("busy_hi", 32'(bus.busy), 32'd1);
      chk("hold_hi", bus.HI, cur[63:32]);
      chk("hold_lo", bus.LO, cur[31:0]);
      if (inj != 0 && i == 1) begin
        bus.start = 1'b1;
        bus.MDUOp = 4'(inj);
        bus.A     = $urandom;
        bus.B     = $urandom;
      end
      @(negedge clk);
      bus.start = 1'b0;
      bus.MDUOp = 4'd0;
    end
    chk("busy_lo", 32'(bus.busy), 32'd0);
    chk("res_hi", bus.HI, nxt[63:32]);
    chk("res_lo", bus.LO, nxt[31:0]);
    mhi = nxt[63:32];
    mlo = nxt[31:0];
  endtask

  task automatic abort_mult(input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.MDUOp = 4'd1;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.MDUOp = 4'd0;
    for (int i = 0; i < 2; i++) begin
      chk("abort_busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort_busy0", 32'(bus.busy), 32'd0);
    chk("abort_hi", bus.HI, 32'd0);
    chk("abort_lo", bus.LO, 32'd0);
    mhi = '0;
    mlo = '0;
    @(negedge clk);
    chk("abort_stays", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int ops[12];
    int op, inj;
    logic [31:0] a, b;
    ops = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 13};
    total = 0;
    bad   = 0;
    clk   = 1'b0;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.MDUOp = 4'd0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_hi", bus.HI, 32'd0);
    chk("rst_lo", bus.LO, 32'd0);
    reset = 1'b1;
    mhi = '0;
    mlo = '0;

    run_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op(2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op(3, 32'hFFFFFFF9, 32'd2, 0);
    run_op(4, 32'd7, 32'd2, 0);
    run_op(5, 32'h12345678, 32'd0, 0);
    run_op(4, 32'd99, 32'd0, 0);
    run_op(3, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(13, 32'hDEADBEEF, 32'd1, 0);
    run_op(1, 32'h00001234, 32'hFFFF0001, 5);
    run_op(3, 32'h7FFFFFFF, 32'h00000003, 2);
    abort_mult(32'h0000FFFF, 32'h0000FFFF);
    run_op(6, 32'd10, 32'd0, 0);
    run_op(7, 32'd3, 32'd4, 0);

    for (int k = 0; k < 80; k++) begin
      op = ops[$urandom_range(0, 11)];
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 15) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      inj = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
      run_op(op, a, b, inj);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
